// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for seq_alu and the downstream datapath decoder.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_NOTA = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_ADD  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_CMP  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_SHL  = 4'b1010;
  localparam logic [3:0] OP_ASL  = 4'b1011;
  localparam logic [3:0] OP_LSR  = 4'b1100;
  localparam logic [3:0] OP_ASR  = 4'b1101;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per clock, WIDTH clocks.
module seq_alu_mul #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc_next;

  always_comb begin
    acc_next = acc + (b_sh[0] ? a_sh : '0);
  end

  // product is the accumulator value that the final iteration is about to store
  assign product = acc_next;
  assign done    = busy && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
      a_sh <= '0;
      b_sh <= '0;
    end else if (load) begin
      busy <= 1'b1;
      cnt  <= '0;
      acc  <= '0;
      a_sh <= {{WIDTH{1'b0}}, a};
      b_sh <= b;
    end else if (busy) begin
      acc  <= acc_next;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with start/ready handshake; single-cycle ops plus iterative MUL.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             Cout,
  output logic             Negative,
  output logic             Zero,
  output logic             Overflow
);

  state_t state, state_next;

  logic               accept;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_sum;
  logic [WIDTH-1:0]   res;
  logic               wr_y;
  logic               res_c;
  logic               res_v;

  assign ready  = (state == S_IDLE) && !rst;
  assign accept = start && ready;

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .load   (accept && (sel == OP_MUL)),
    .a      (A),
    .b      (B),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept && (sel == OP_MUL)) state_next = S_MUL;
      S_MUL:  if (mul_done || !mul_busy)     state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign add_sum = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
  assign sub_sum = {1'b0, A} + {1'b0, ~B} + (WIDTH + 1)'(1);

  always_comb begin
    res   = '0;
    wr_y  = 1'b1;
    res_c = 1'b0;
    res_v = 1'b0;
    case (sel)
      OP_AND:  res = A & B;
      OP_OR:   res = A | B;
      OP_NOTA: res = ~A;
      OP_NOR:  res = ~(A | B);
      OP_XOR:  res = A ^ B;
      OP_NAND: res = ~(A & B);
      OP_ADD: begin
        res   = add_sum[WIDTH-1:0];
        res_c = add_sum[WIDTH];
        res_v = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        res   = sub_sum[WIDTH-1:0];
        res_c = sub_sum[WIDTH];
        res_v = (A[WIDTH-1] != B[WIDTH-1]) && (sub_sum[WIDTH-1] != A[WIDTH-1]);
        wr_y  = (sel == OP_SUB);
      end
      OP_SHL: begin
        res   = A << 1;
        res_c = A[WIDTH-1];
      end
      OP_ASL: begin
        res   = A << 1;
        res_c = A[WIDTH-1];
        res_v = A[WIDTH-1] ^ A[WIDTH-2];
      end
      OP_LSR: begin
        res   = A >> 1;
        res_c = A[0];
      end
      OP_ASR: begin
        res   = $unsigned($signed(A) >>> 1);
        res_c = A[0];
      end
      default: res = '0;
    endcase
  end

  // CMP takes Negative/Zero from the difference even though Y is left untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      Y        <= '0;
      Cout     <= 1'b0;
      Negative <= 1'b0;
      Zero     <= 1'b0;
      Overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept && (sel != OP_MUL)) begin
        if (wr_y) Y <= res;
        Cout     <= res_c;
        Negative <= res[WIDTH-1];
        Zero     <= (res == '0);
        Overflow <= res_v;
        done     <= 1'b1;
      end else if ((state == S_MUL) && mul_done) begin
        Y        <= mul_product[WIDTH-1:0];
        Cout     <= (mul_product[2*WIDTH-1:WIDTH] != '0);
        Overflow <= (mul_product[2*WIDTH-1:WIDTH] != '0);
        Negative <= mul_product[WIDTH-1];
        Zero     <= (mul_product[WIDTH-1:0] == '0);
        done     <= 1'b1;
      end
    end
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Registered, parametrised ALU: the next generation of the lab-2 combinational ALU. It performs full-width bitwise operations rather than bit 0 only, adds an iterative multiply on the previously unused code 1001, and provides a compare op. Operands enter through a start/ready handshake. Results and flags are registered and held. It sits between the operand register file and the writeback/flag register of the lab datapath.

## Interface
- WIDTH, 32, operand/result width (≥4)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted when start & ready at a clk edge
- sel  in  4  opcode, sampled on accept
- A, B  in  WIDTH  operands, sampled on accept
- Cin  in  1  carry in (ADD only), sampled on accept
- ready  out  1  block idle, can accept
- done  out  1  one-cycle pulse: Y/flags updated this cycle
- Y  out  WIDTH  result (registered, held)
- Cout, Negative, Zero, Overflow  out  1 each  flags (registered, held)

## Operation
- Opcodes: 0000 AND, 0001 OR, 0010 NOT A, 0011 NOR, 0100 XOR, 0101 NAND (all bitwise over WIDTH); 0110 ADD A+B+Cin; 0111 SUB A−B; 1000 CMP; 1001 MUL; 1010 SHL; 1011 ASL; 1100 LSR; 1101 ASR (all shifts by 1); 1110/1111 reserved.
- Default flags: Negative = Y[W−1], Zero = (Y==0), Cout = 0, Overflow = 0.
- ADD: Cout = carry out of bit W−1. Overflow = (A[W−1]==B[W−1]) & (Y[W−1]!=A[W−1]).
- SUB: Y = A+~B+1. Cout = no-borrow (1 iff A ≥ B unsigned). Overflow = (A[W−1]!=B[W−1]) & (Y[W−1]!=A[W−1]).
- CMP: computes the SUB flags. Y is not written and keeps its previous value. Zero/Negative come from the difference.
- SHL/ASL: Y = A<<1, Cout = A[W−1]. Overflow = 0 for SHL, A[W−1]^A[W−2] for ASL.
- LSR: Y = A>>1, ASR: Y = A>>>1 (sign fill). Cout = A[0] for both. Negative = Y[W−1].
- MUL: unsigned shift-add over WIDTH iterations. Y = low WIDTH bits of A*B. Cout = Overflow = (high WIDTH bits ≠ 0).
- Reserved: Y = 0, Zero = 1, other flags 0, done pulses normally.
- FSM: IDLE → (accept, sel≠1001) IDLE with result registered; IDLE → (accept MUL) MUL; MUL → IDLE when iteration counter reaches WIDTH−1.
- ready = (state==IDLE) & ~rst.
- start while ready=0 is ignored, not queued.

## Timing
- Reset (rst high at an edge): Y=0, all flags 0, done=0, state IDLE, counter 0. During that cycle ready=0, and ready=1 from the next cycle.
- Reset during MUL aborts the operation: no done, outputs cleared as above.
- Single-cycle ops: accepted at edge k → Y/flags/done valid after edge k. Back-to-back accepts every cycle are allowed, and done stays high across consecutive results.
- MUL: accepted at edge k → ready=0 after k. Iterations run at edges k+1..k+WIDTH. Y/flags/done are valid after edge k+WIDTH, and ready returns high in the same cycle. A new start in that cycle is accepted.
- done is high for exactly one cycle per accepted op.
- Y and flags hold between done pulses. During MUL they keep the previous result.
- Carry/overflow arithmetic uses a WIDTH+1-bit sum. The MUL accumulator is 2·WIDTH bits.

## Structure
- Package alu_pkg holds the opcode localparams (OP_AND…OP_ASR, OP_MUL, OP_CMP) and the state encoding (S_IDLE, S_MUL). The successor datapath decoder imports them.
- Sub-module seq_alu_mul: iterative multiplier with load/busy/done. It owns the 2·WIDTH-bit accumulator and the counter. seq_alu owns the handshake, the single-cycle ops and the flag registers.

## Test plan
- Reset mid-MUL (WIDTH=32): start MUL A=3,B=5, assert rst at cycle 5 → no done, Y=0, flags 0, ready=1 in the cycle after rst drops.
- ADD overflow: A=0x7FFFFFFF, B=1, Cin=0 → Y=0x80000000, Negative=1, Overflow=1, Cout=0, done one cycle after accept.
- SUB/CMP: A=5, B=5 SUB → Y=0, Zero=1, Cout=1. Then CMP A=3, B=7 → Y stays 0, Negative=1, Cout=0, Zero=0.
- MUL (WIDTH=8): A=0x10, B=0x10 → done 8 cycles after accept, Y=0x00, Cout=Overflow=1, Zero=1. A=12, B=11 → Y=132 (0x84), Cout=0.
- Busy handling: start ADD held during a MUL → ignored. After MUL done, ADD accepted the same cycle → done next cycle.
- Shifts/bitwise back-to-back: AND 0xF0F0_F0F0 & 0xFF00_FF00 → 0xF000_F000, then ASR 0x8000_0001 → 0xC000_0000 with Cout=1, then ASL 0x4000_0000 → Overflow=1. Three consecutive done cycles.
